video_out_ctl: RTL
==================

# video_out_ctl

Sequencer and output stage for the video DAC pins. It owns the choice between VGA RGB, composite (1-bit sigma-delta on the RGB pins), S-video (1-bit sigma-delta luma/chroma) and off, and switches between them only at frame boundaries. The outputs are blanked for a programmable number of frames so the monitor never sees a torn frame. It sits between the video generator / TV encoder and the top-level pins, and takes mode requests from the OSD/keyboard control logic.

## Interface
Parameters:
- BLANK_FRAMES, 2: number of whole frames all outputs are forced to zero after a switch (0..15).
- RESET_MODE, 2'b00: mode after reset.

Mode encoding: 00 VGA, 01 composite, 10 S-video, 11 off.

Ports:
- clk24  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ce_pwm  in  1  sigma-delta update enable (colour-mod rate).
- mode_req  in  2  requested mode.
- mode_req_stb  in  1  one-cycle request strobe.
- mode_busy  out  1  switch in progress.
- mode_cur  out  2  mode currently applied.
- video_r, video_g, video_b  in  4 each  RGB from the video generator.
- vga_hs, vga_vs  in  1 each  syncs, active-low.
- tv_cvbs, tv_luma, tv_chroma  in  5 each  TV encoder levels.
- VGA_R, VGA_G, VGA_B  out  4 each  pin DAC.
- VGA_HS, VGA_VS  out  1 each  registered syncs.
- S_VIDEO_Y, S_VIDEO_C  out  1 each  sigma-delta bitstreams.

## Operation
- Every output is registered.
- Reset values:
  - state ACTIVE; mode_cur = RESET_MODE; mode_busy = 0.
  - All colour and S-video outputs = 0; VGA_HS = VGA_VS = 1.
  - Accumulators (6 bit: cvbs, luma, chroma) = 0; vs_d = 1.
- Frame edge: vs_d <= vga_vs every cycle. The edge is vs_d==1 && vga_vs==0, evaluated in the same cycle.
- FSM:
  - ACTIVE: on stb with mode_req != mode_cur, latch pending <= mode_req, set mode_busy, go to WAIT_VS. On stb with mode_req == mode_cur, do nothing.
  - WAIT_VS: outputs keep driving the old mode.
    - A stb updates pending.
    - A stb equal to mode_cur cancels the switch: clear mode_busy, go to ACTIVE.
    - On a frame edge: mode_cur <= pending, cnt <= BLANK_FRAMES, go to BLANK. If BLANK_FRAMES==0, go straight to ACTIVE and clear mode_busy.
  - BLANK: all colour and S-video outputs are 0 and all accumulators are held at 0. Each frame edge decrements cnt. The edge that takes cnt to 0 moves to ACTIVE and clears mode_busy. Any stb is ignored.
- Datapath in ACTIVE, and in WAIT_VS using the old mode:
  - VGA: VGA_R/G/B <= video_r/g/b; S-video outputs are 0.
  - Composite: when ce_pwm, acc_c <= {1'b0, acc_c[4:0]} + tv_cvbs. VGA_R/G/B <= {4{acc_c[5]}}.
  - S-video: same update for acc_y with tv_luma and acc_ch with tv_chroma. S_VIDEO_Y <= acc_y[5], S_VIDEO_C <= acc_ch[5]. VGA_R/G/B are 0.
  - Off: all colour and S-video outputs are 0.
  - Accumulators of unused paths are held at 0.
  - Arithmetic is 6-bit unsigned; the carry is the output bit, and the top bit is discarded on the next update.
- VGA_HS/VGA_VS are vga_hs/vga_vs delayed one cycle in every state and mode, so they stay aligned with the colour outputs.

## Timing
- Input to pin latency is 1 cycle for all paths.
- mode_busy rises the cycle after an accepted stb.
- On the frame-edge cycle, the next-cycle outputs already reflect BLANK (or the new mode if BLANK_FRAMES==0). mode_cur updates on the same edge.
- mode_busy falls the cycle after the last blanking frame edge. The new mode's data appears on the same cycle.
- When ce_pwm is low, the accumulators hold their value and the sigma-delta outputs hold their last bit.
- Simultaneous stb and frame edge in WAIT_VS: the stb's value is used as pending for that edge. If that value equals mode_cur, the cancel takes priority.
- A reset_n assertion mid-switch returns to the reset values immediately (asynchronously). No pending request survives.

## Test plan
- Reset with RESET_MODE=00 and video_r=4'hA -> VGA_R=0 during reset, 4'hA one cycle after release; mode_busy=0.
- Request 01 in VGA with BLANK_FRAMES=2 -> busy next cycle; VGA_R keeps tracking video_r until the vs edge; then 0 for 2 frames; mode_cur=01 from the first edge; busy drops after the 3rd edge.
- Composite with tv_cvbs=16 and ce_pwm held high -> VGA_R alternates 0/F (50% duty); tv_cvbs=0 -> constant 0; tv_cvbs=31 -> 31 ones in every 32 cycles.
- S-video with luma=8, chroma=24 -> Y duty 1/4, C duty 3/4; VGA_R/G/B stay 0; ce_pwm low freezes both bits.
- In WAIT_VS, stb of 10 then stb of 00 (the current mode) -> switch cancelled, no blanking, busy=0, mode_cur stays 00.
- BLANK_FRAMES=0 and a stb arriving in the same cycle as a vs edge -> new mode's output appears on the next cycle; reset_n pulse during BLANK -> state ACTIVE, mode_cur=RESET_MODE.

Source files
------------

// File: rtl/video_out_ctl.sv
// Video DAC pin sequencer: VGA/composite/S-video/off, switched only at frame edges with blanking.
// Latency 1 cycle input-to-pin; no backpressure (mode_busy reports a switch in progress).
module video_out_ctl #(
    parameter int unsigned BLANK_FRAMES = 2,
    parameter logic [1:0]  RESET_MODE   = 2'b00
) (
    input  logic       clk24,
    input  logic       reset_n,
    input  logic       ce_pwm,
    input  logic [1:0] mode_req,
    input  logic       mode_req_stb,
    output logic       mode_busy,
    output logic [1:0] mode_cur,
    input  logic [3:0] video_r,
    input  logic [3:0] video_g,
    input  logic [3:0] video_b,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [4:0] tv_cvbs,
    input  logic [4:0] tv_luma,
    input  logic [4:0] tv_chroma,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       S_VIDEO_Y,
    output logic       S_VIDEO_C
);

    localparam logic [1:0] MODE_VGA  = 2'b00;
    localparam logic [1:0] MODE_COMP = 2'b01;
    localparam logic [1:0] MODE_SVID = 2'b10;
    localparam logic [3:0] BLANK_CNT = 4'(BLANK_FRAMES);

    typedef enum logic [1:0] {ST_ACTIVE, ST_WAIT_VS, ST_BLANK} state_t;

    state_t     state, state_nxt;
    logic [1:0] pending, pending_nxt, mode_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       busy_nxt;
    logic       vs_d;
    logic       frame_edge;
    logic [5:0] acc_c, acc_y, acc_ch;
    logic [5:0] acc_c_nxt, acc_y_nxt, acc_ch_nxt;
    logic [3:0] r_nxt, g_nxt, b_nxt;

    assign frame_edge = vs_d & ~vga_vs;

    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_cur;
        pending_nxt = pending;
        cnt_nxt     = cnt;
        busy_nxt    = mode_busy;
        case (state)
            ST_ACTIVE: begin
                if (mode_req_stb && mode_req != mode_cur) begin
                    pending_nxt = mode_req;
                    busy_nxt    = 1'b1;
                    state_nxt   = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (mode_req_stb)
                    pending_nxt = mode_req;
                // A request back to the live mode wins over a coincident frame edge.
                if (mode_req_stb && mode_req == mode_cur) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_ACTIVE;
                end else if (frame_edge) begin
                    mode_nxt = pending_nxt;
                    cnt_nxt  = BLANK_CNT;
                    if (BLANK_CNT == 4'd0) begin
                        busy_nxt  = 1'b0;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        state_nxt = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (frame_edge) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        busy_nxt  = 1'b0;
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // Datapath follows the next state so the pins switch on the same edge as the FSM.
    always_comb begin
        acc_c_nxt  = 6'd0;
        acc_y_nxt  = 6'd0;
        acc_ch_nxt = 6'd0;
        r_nxt      = 4'd0;
        g_nxt      = 4'd0;
        b_nxt      = 4'd0;
        if (state_nxt != ST_BLANK) begin
            case (mode_nxt)
                MODE_VGA: begin
                    r_nxt = video_r;
                    g_nxt = video_g;
                    b_nxt = video_b;
                end
                MODE_COMP: begin
                    acc_c_nxt = ce_pwm ? ({1'b0, acc_c[4:0]} + {1'b0, tv_cvbs}) : acc_c;
                    r_nxt     = {4{acc_c_nxt[5]}};
                    g_nxt     = {4{acc_c_nxt[5]}};
                    b_nxt     = {4{acc_c_nxt[5]}};
                end
                MODE_SVID: begin
                    acc_y_nxt  = ce_pwm ? ({1'b0, acc_y[4:0]} + {1'b0, tv_luma}) : acc_y;
                    acc_ch_nxt = ce_pwm ? ({1'b0, acc_ch[4:0]} + {1'b0, tv_chroma}) : acc_ch;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ACTIVE;
            mode_cur  <= RESET_MODE;
            mode_busy <= 1'b0;
            pending   <= RESET_MODE;
            cnt       <= 4'd0;
            vs_d      <= 1'b1;
            acc_c     <= 6'd0;
            acc_y     <= 6'd0;
            acc_ch    <= 6'd0;
            VGA_R     <= 4'd0;
            VGA_G     <= 4'd0;
            VGA_B     <= 4'd0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            S_VIDEO_Y <= 1'b0;
            S_VIDEO_C <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_cur  <= mode_nxt;
            mode_busy <= busy_nxt;
            pending   <= pending_nxt;
            cnt       <= cnt_nxt;
            vs_d      <= vga_vs;
            acc_c     <= acc_c_nxt;
            acc_y     <= acc_y_nxt;
            acc_ch    <= acc_ch_nxt;
            VGA_R     <= r_nxt;
            VGA_G     <= g_nxt;
            VGA_B     <= b_nxt;
            VGA_HS    <= vga_hs;
            VGA_VS    <= vga_vs;
            S_VIDEO_Y <= acc_y_nxt[5];
            S_VIDEO_C <= acc_ch_nxt[5];
        end
    end

endmodule
